// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - tile sequencer for a ROWS x COLS PE grid
module pe_array_sequencer #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int K_W  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      cfg_mode,
   input  logic [K_W-1:0]  cfg_k,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [1:0]      dataflow_sel,
   output logic            array_rst_n,
   output logic [ROWS-1:0] preload_row_en,
   output logic            feed_valid,
   output logic [K_W-1:0]  feed_idx,
   output logic [COLS-1:0] psum_valid
);

   // Wide enough for k + ROWS + COLS, the longest STREAM+FLUSH span.
   localparam int CW = K_W + $clog2(ROWS + COLS) + 1;

   localparam logic [1:0] MODE_OS  = 2'b10;
   localparam logic [1:0] MODE_BAD = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_PRELOAD,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [1:0]      mode, mode_nxt;
   logic [K_W-1:0]  k, k_nxt;

   logic            err_nxt, busy_nxt, done_nxt, arst_nxt, fv_nxt;
   logic [ROWS-1:0] pre_nxt;
   logic [K_W-1:0]  idx_nxt;
   logic [COLS-1:0] psum_nxt;

   // The mode register is the value broadcast to the PEs; it only moves on an accepted start.
   assign dataflow_sel = mode;

   // State, counter and latched tile configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         mode  <= 2'b00;
         k     <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         mode  <= mode_nxt;
         k     <= k_nxt;
      end
   end

   // Next state; cnt indexes the preload row, then runs from 0 across STREAM and FLUSH.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mode_nxt  = mode;
      k_nxt     = k;
      err_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (start) begin
               if (cfg_mode == MODE_BAD || cfg_k == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  mode_nxt  = cfg_mode;
                  k_nxt     = cfg_k;
                  state_nxt = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            cnt_nxt   = '0;
            state_nxt = (mode == MODE_OS) ? S_STREAM : S_PRELOAD;
         end
         S_PRELOAD: begin
            if (cnt == CW'(ROWS - 1)) begin
               cnt_nxt   = '0;
               state_nxt = S_STREAM;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_STREAM: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CW'(k) - 1'b1) state_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CW'(k) + CW'(ROWS + COLS - 2)) state_nxt = S_DONE;
         end
         S_DONE: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state so the outputs can be registered.
   always_comb begin
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_DONE);
      arst_nxt = (state_nxt != S_CLEAR);
      fv_nxt   = (state_nxt == S_STREAM);
      pre_nxt  = '0;
      idx_nxt  = '0;
      psum_nxt = '0;
      if (state_nxt == S_PRELOAD) pre_nxt = ROWS'(1) << cnt_nxt;
      if (state_nxt == S_STREAM)  idx_nxt = cnt_nxt[K_W-1:0];
      // Column c sees its first result ROWS+c cycles after the first vector enters.
      if ((state_nxt == S_STREAM || state_nxt == S_FLUSH) && mode_nxt != MODE_OS) begin
         for (int c = 0; c < COLS; c++) begin
            psum_nxt[c] = (cnt_nxt >= CW'(ROWS + c)) &&
                          (cnt_nxt <  CW'(ROWS + c) + CW'(k_nxt));
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         array_rst_n    <= 1'b1;
         preload_row_en <= '0;
         feed_valid     <= 1'b0;
         feed_idx       <= '0;
         psum_valid     <= '0;
      end else begin
         busy           <= busy_nxt;
         done           <= done_nxt;
         err            <= err_nxt;
         array_rst_n    <= arst_nxt;
         preload_row_en <= pre_nxt;
         feed_valid     <= fv_nxt;
         feed_idx       <= idx_nxt;
         psum_valid     <= psum_nxt;
      end
   end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb/tb_pe_array_sequencer.sv - randomized self-checking bench for pe_array_sequencer
module tb_pe_array_sequencer;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int K_W  = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [1:0]      cfg_mode = 2'b00;
   logic [K_W-1:0]  cfg_k = '0;
   logic            busy, done, err, array_rst_n, feed_valid;
   logic [1:0]      dataflow_sel;
   logic [ROWS-1:0] preload_row_en;
   logic [K_W-1:0]  feed_idx;
   logic [COLS-1:0] psum_valid;

   pe_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .cfg_mode       (cfg_mode),
      .cfg_k          (cfg_k),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .dataflow_sel   (dataflow_sel),
      .array_rst_n    (array_rst_n),
      .preload_row_en (preload_row_en),
      .feed_valid     (feed_valid),
      .feed_idx       (feed_idx),
      .psum_valid     (psum_valid)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_seen = 0;

   // Reference model: one tile described by its accept edge, mode and length.
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [1:0] m_mode   = 2'b00;
   int         m_k      = 0;
   logic [1:0] m_dsel   = 2'b00;
   int         m_err_at = -10;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Offset of the DONE cycle from the accept edge.
   function automatic int tile_end(input logic [1:0] mode, input int k);
      int pre;
      pre = (mode == 2'b10) ? 0 : ROWS;
      return 2 + pre + k + ROWS + COLS - 1;
   endfunction

   task automatic check_outputs();
      int d, s, dl;
      logic e_busy, e_done, e_arst, e_fv;
      logic [ROWS-1:0] e_pre;
      logic [K_W-1:0]  e_idx;
      logic [COLS-1:0] e_psum;
      e_busy = 1'b0; e_done = 1'b0; e_arst = 1'b1; e_fv = 1'b0;
      e_pre = '0; e_idx = '0; e_psum = '0;
      if (m_active) begin
         d  = cyc - m_t;
         s  = 2 + ((m_mode == 2'b10) ? 0 : ROWS);
         dl = tile_end(m_mode, m_k);
         if (d >= 1 && d <= dl) begin
            e_busy = 1'b1;
            e_done = (d == dl);
            e_arst = (d != 1);
            if (d >= 2 && d < s) e_pre[d-2] = 1'b1;
            if (d >= s && d < s + m_k) begin
               e_fv  = 1'b1;
               e_idx = K_W'(d - s);
            end
            if (m_mode != 2'b10) begin
               for (int c = 0; c < COLS; c++) begin
                  if (d >= s + ROWS + c && d < s + ROWS + c + m_k) e_psum[c] = 1'b1;
               end
            end
         end
      end
      check("busy",           32'(busy),           32'(e_busy));
      check("done",           32'(done),           32'(e_done));
      check("err",            32'(err),            32'(cyc == m_err_at));
      check("dataflow_sel",   32'(dataflow_sel),   32'(m_dsel));
      check("array_rst_n",    32'(array_rst_n),    32'(e_arst));
      check("preload_row_en", 32'(preload_row_en), 32'(e_pre));
      check("feed_valid",     32'(feed_valid),     32'(e_fv));
      check("feed_idx",       32'(feed_idx),       32'(e_idx));
      check("psum_valid",     32'(psum_valid),     32'(e_psum));
   endtask

   // One clock: check the current cycle, drive inputs, advance the model at the edge.
   task automatic step(input logic st, input logic [1:0] m, input int k);
      @(negedge clk);
      check_outputs();
      if (done === 1'b1) done_seen++;
      start    = st;
      cfg_mode = m;
      cfg_k    = K_W'(k);
      @(posedge clk);
      if (rst_n && st && (!m_active || cyc > m_t + tile_end(m_mode, m_k))) begin
         if (m == 2'b11 || k == 0) begin
            m_err_at = cyc + 1;
         end else begin
            m_active = 1'b1;
            m_t      = cyc;
            m_mode   = m;
            m_k      = k;
            m_dsel   = m;
         end
      end
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'($urandom % 4), $urandom_range(0, 20));
   endtask

   initial begin
      int d0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst_n = 1'b1;

      // WS, K=3
      step(1'b1, 2'b00, 3);
      idle_steps(20);
      // OS, K=2
      step(1'b1, 2'b10, 2);
      idle_steps(14);
      // illegal mode, then illegal k; dataflow_sel stays at OS
      step(1'b1, 2'b11, 5);
      idle_steps(2);
      step(1'b1, 2'b01, 0);
      idle_steps(2);
      check("dsel_after_err", 32'(dataflow_sel), 32'(2'b10));
      // start held high across a K=5 WS tile
      d0 = done_seen;
      for (int i = 0; i < 20; i++) step(1'b1, 2'b00, 5);
      check("one_done_held_start", 32'(done_seen - d0), 32'd1);
      idle_steps(25);

      // reset while feed_idx == 2
      step(1'b1, 2'b00, 5);
      idle_steps(7);
      @(negedge clk);
      check_outputs();
      check("feed_idx_before_rst", 32'(feed_idx), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy",        32'(busy),           32'd0);
      check("rst_done",        32'(done),           32'd0);
      check("rst_array_rst_n", 32'(array_rst_n),    32'd1);
      check("rst_feed_valid",  32'(feed_valid),     32'd0);
      check("rst_feed_idx",    32'(feed_idx),       32'd0);
      check("rst_preload",     32'(preload_row_en), 32'd0);
      check("rst_psum",        32'(psum_valid),     32'd0);
      check("rst_dsel",        32'(dataflow_sel),   32'd0);
      m_active = 1'b0;
      m_dsel   = 2'b00;
      m_err_at = -10;
      @(posedge clk);
      cyc++;
      idle_steps(2);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      cyc++;
      step(1'b1, 2'b01, 4);
      idle_steps(25);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 4) == 0, 2'($urandom % 4),
              (($urandom % 8) == 0) ? 0 : $urandom_range(1, 12));
      end
      idle_steps(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
